// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: steers the ioctl ROM download stream into byte-wide BRAM
// (below BRAM_LIMIT) or 16-bit SDRAM words (at/above BRAM_LIMIT), pairing
// even/odd bytes, running the SDRAM req/ack handshake and throttling the HPS.
// Optional feature: define ROM_LOAD_CHECKSUM_EN to add the 16-bit `checksum`
// output (wrapping sum of every accepted byte).
module rom_load_sequencer #(
   parameter logic [24:0] BRAM_LIMIT = 25'h80000,
   parameter int unsigned SDR_AW     = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic              bram_wr,
   output logic [24:0]       bram_addr,
   output logic [7:0]        bram_data,
   output logic              sdr_req,
   input  logic              sdr_ack,
   output logic [SDR_AW-1:0] sdr_addr,
   output logic [15:0]       sdr_data,
   output logic [1:0]        sdr_be,
   output logic              rom_ready,
   output logic              overrun
`ifdef ROM_LOAD_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   localparam int unsigned ADDR_W = 25;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

   state_t state, state_n;

   logic                dl_q;
   logic                pend_valid, pend_valid_n;
   logic                pend_odd, pend_odd_n;
   logic [SDR_AW-1:0]   pend_addr, pend_addr_n;
   logic [BYTE_W-1:0]   pend_data, pend_data_n;
   logic                req_n;
   logic [SDR_AW-1:0]   addr_n;
   logic [WORD_W-1:0]   data_n;
   logic [1:0]          be_n;

   logic                dl_rise, dl_fall, start;
   logic                in_sdr, wr_odd, accept, drop;
   logic [ADDR_W-1:0]   offs;
   logic [SDR_AW-1:0]   wr_word;

   assign dl_rise = ioctl_download & ~dl_q;
   assign dl_fall = ~ioctl_download & dl_q;
   // A new download may start from IDLE or from the single DONE cycle.
   assign start   = ((state == IDLE) || (state == DONE)) && dl_rise;
   assign in_sdr  = (ioctl_addr >= BRAM_LIMIT);
   assign offs    = ioctl_addr - BRAM_LIMIT;
   assign wr_odd  = offs[0];
   assign wr_word = SDR_AW'(offs[ADDR_W-1:1]);
   assign accept  = (state == LOAD) && ioctl_wr && !ioctl_wait;
   assign drop    = (state == LOAD) && ioctl_wr && ioctl_wait;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (dl_rise) state_n = LOAD;
         LOAD:    if (dl_fall) state_n = FLUSH;
         FLUSH:   if (!sdr_req && !pend_valid) state_n = DONE;
         DONE:    state_n = start ? LOAD : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Byte pairing and SDRAM request issue; accepted strobes imply sdr_req idle.
   always_comb begin
      req_n        = sdr_req;
      addr_n       = sdr_addr;
      data_n       = sdr_data;
      be_n         = sdr_be;
      pend_valid_n = pend_valid;
      pend_odd_n   = pend_odd;
      pend_addr_n  = pend_addr;
      pend_data_n  = pend_data;
      if (sdr_req && sdr_ack) req_n = 1'b0;
      if (start) begin
         pend_valid_n = 1'b0;
         pend_odd_n   = 1'b0;
      end else if (accept && in_sdr) begin
         if (!wr_odd) begin
            if (pend_valid) begin
               req_n  = 1'b1;
               addr_n = pend_addr;
               data_n = {8'h00, pend_data};
               be_n   = 2'b01;
            end
            pend_valid_n = 1'b1;
            pend_odd_n   = 1'b0;
            pend_addr_n  = wr_word;
            pend_data_n  = ioctl_dout;
         end else if (pend_valid && (pend_addr == wr_word)) begin
            req_n        = 1'b1;
            addr_n       = wr_word;
            data_n       = {ioctl_dout, pend_data};
            be_n         = 2'b11;
            pend_valid_n = 1'b0;
         end else if (pend_valid) begin
            // Unrelated even byte goes out first; the odd byte queues behind it.
            req_n        = 1'b1;
            addr_n       = pend_addr;
            data_n       = {8'h00, pend_data};
            be_n         = 2'b01;
            pend_odd_n   = 1'b1;
            pend_addr_n  = wr_word;
            pend_data_n  = ioctl_dout;
         end else begin
            req_n  = 1'b1;
            addr_n = wr_word;
            data_n = {ioctl_dout, 8'h00};
            be_n   = 2'b10;
         end
      end else if (pend_valid && !sdr_req &&
                   (((state == LOAD) && pend_odd) || (state == FLUSH))) begin
         req_n        = 1'b1;
         addr_n       = pend_addr;
         data_n       = pend_odd ? {pend_data, 8'h00} : {8'h00, pend_data};
         be_n         = pend_odd ? 2'b10 : 2'b01;
         pend_valid_n = 1'b0;
         pend_odd_n   = 1'b0;
      end
   end

   // Registered outputs, pending byte and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dl_q       <= 1'b0;
         pend_valid <= 1'b0;
         pend_odd   <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
         sdr_req    <= 1'b0;
         sdr_addr   <= '0;
         sdr_data   <= '0;
         sdr_be     <= '0;
         ioctl_wait <= 1'b0;
         bram_wr    <= 1'b0;
         bram_addr  <= '0;
         bram_data  <= '0;
         rom_ready  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         dl_q       <= ioctl_download;
         pend_valid <= pend_valid_n;
         pend_odd   <= pend_odd_n;
         pend_addr  <= pend_addr_n;
         pend_data  <= pend_data_n;
         sdr_req    <= req_n;
         sdr_addr   <= addr_n;
         sdr_data   <= data_n;
         sdr_be     <= be_n;
         ioctl_wait <= req_n | (pend_valid_n & pend_odd_n);
         bram_wr    <= accept && !in_sdr;
         if (accept && !in_sdr) begin
            bram_addr <= ioctl_addr;
            bram_data <= ioctl_dout;
         end
         if (start) begin
            rom_ready <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (drop)             overrun   <= 1'b1;
            if (state_n == DONE)  rom_ready <= 1'b1;
         end
      end
   end

`ifdef ROM_LOAD_CHECKSUM_EN
   // Wrapping sum of every accepted byte in either region.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       checksum <= '0;
      else if (start)  checksum <= '0;
      else if (accept) checksum <= checksum + WORD_W'(ioctl_dout);
   end
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: scoreboard queues hold expected BRAM writes and
// SDRAM requests; a forked monitor acknowledges requests and pops/compares.
module tb_rom_load_sequencer;

   localparam int unsigned SDR_AW = 24;

   logic              clk;
   logic              reset;
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              ioctl_wait;
   logic              bram_wr;
   logic [24:0]       bram_addr;
   logic [7:0]        bram_data;
   logic              sdr_req;
   logic              sdr_ack;
   logic [SDR_AW-1:0] sdr_addr;
   logic [15:0]       sdr_data;
   logic [1:0]        sdr_be;
   logic              rom_ready;
   logic              overrun;
`ifdef ROM_LOAD_CHECKSUM_EN
   logic [15:0]       checksum;
`endif

   typedef struct {
      logic [SDR_AW-1:0] addr;
      logic [15:0]       data;
      logic [1:0]        be;
   } sdr_exp_t;

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
   } bram_exp_t;

   sdr_exp_t  sdr_q[$];
   bram_exp_t bram_q[$];
   int        n_checks;
   int        n_pass;
   int        ack_lat;
   bit        ack_en;

   rom_load_sequencer #(.BRAM_LIMIT(25'h80000), .SDR_AW(SDR_AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .bram_wr        (bram_wr),
      .bram_addr      (bram_addr),
      .bram_data      (bram_data),
      .sdr_req        (sdr_req),
      .sdr_ack        (sdr_ack),
      .sdr_addr       (sdr_addr),
      .sdr_data       (sdr_data),
      .sdr_be         (sdr_be),
      .rom_ready      (rom_ready),
      .overrun        (overrun)
`ifdef ROM_LOAD_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void push_sdr(input logic [SDR_AW-1:0] a, input logic [15:0] d,
                                    input logic [1:0] be);
      sdr_exp_t e;
      e.addr = a;
      e.data = d;
      e.be   = be;
      sdr_q.push_back(e);
   endfunction

   function automatic void push_bram(input logic [24:0] a, input logic [7:0] d);
      bram_exp_t e;
      e.addr = a;
      e.data = d;
      bram_q.push_back(e);
   endfunction

   // SDRAM controller model and output monitor (runs at negedge).
   task automatic monitor();
      bit        busy;
      int        cnt;
      sdr_exp_t  cur, e;
      bram_exp_t b;
      busy = 0;
      cnt  = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            busy    = 0;
            cnt     = 0;
            sdr_ack = 1'b0;
         end else begin
            sdr_ack = 1'b0;
            if (bram_wr) begin
               n_checks++;
               if (bram_q.size() == 0)
                  $display("FAIL bram_unexpected got addr=%h data=%h, expected no write", bram_addr, bram_data);
               else begin
                  b = bram_q.pop_front();
                  if (bram_addr !== b.addr || bram_data !== b.data)
                     $display("FAIL bram_write got %h/%h expected %h/%h", bram_addr, bram_data, b.addr, b.data);
                  else n_pass++;
               end
            end
            if (sdr_req) begin
               if (!busy) begin
                  busy     = 1;
                  cnt      = 0;
                  cur.addr = sdr_addr;
                  cur.data = sdr_data;
                  cur.be   = sdr_be;
                  n_checks++;
                  if (sdr_q.size() == 0)
                     $display("FAIL sdr_unexpected got addr=%h data=%h be=%b, expected no request", sdr_addr, sdr_data, sdr_be);
                  else begin
                     e = sdr_q.pop_front();
                     if (sdr_addr !== e.addr || sdr_data !== e.data || sdr_be !== e.be)
                        $display("FAIL sdr_request got %h/%h/%b expected %h/%h/%b",
                                 sdr_addr, sdr_data, sdr_be, e.addr, e.data, e.be);
                     else n_pass++;
                  end
               end else begin
                  n_checks++;
                  if (sdr_addr !== cur.addr || sdr_data !== cur.data || sdr_be !== cur.be)
                     $display("FAIL sdr_stable got %h/%h/%b expected %h/%h/%b",
                              sdr_addr, sdr_data, sdr_be, cur.addr, cur.data, cur.be);
                  else n_pass++;
               end
               cnt++;
               if (ack_en && cnt >= ack_lat) sdr_ack = 1'b1;
            end else begin
               busy = 0;
            end
         end
      end
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rom_ready !== 1'b0 || overrun !== 1'b0)
         $display("FAIL start_clear got rom_ready=%b overrun=%b expected 0/0", rom_ready, overrun);
      else n_pass++;
   endtask

   task automatic end_dl();
      int n;
      ioctl_download = 1'b0;
      n = 0;
      while (!rom_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (rom_ready !== 1'b1) $display("FAIL rom_ready got %b expected 1", rom_ready);
      else n_pass++;
      n_checks++;
      if (sdr_q.size() != 0 || bram_q.size() != 0)
         $display("FAIL queues_drained got sdr=%0d bram=%0d expected 0/0", sdr_q.size(), bram_q.size());
      else n_pass++;
      @(negedge clk);
   endtask

   // Strobe one byte once the HPS is allowed to.
   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      int n;
      n = 0;
      while (ioctl_wait && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (ioctl_wait !== 1'b0) $display("FAIL wait_timeout got ioctl_wait=%b expected 0", ioctl_wait);
      else n_pass++;
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({ioctl_wait, bram_wr, sdr_req, rom_ready, overrun} !== 5'b0)
         $display("FAIL reset_flags got %b expected 00000", {ioctl_wait, bram_wr, sdr_req, rom_ready, overrun});
      else n_pass++;
      n_checks++;
      if (sdr_be !== 2'b0 || sdr_addr !== '0 || sdr_data !== 16'h0)
         $display("FAIL reset_sdr got %h/%h/%b expected 0/0/0", sdr_addr, sdr_data, sdr_be);
      else n_pass++;
      n_checks++;
      if (bram_addr !== 25'h0 || bram_data !== 8'h0)
         $display("FAIL reset_bram got %h/%h expected 0/0", bram_addr, bram_data);
      else n_pass++;
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_bram();
      start_dl();
      push_bram(25'h00010, 8'hA5);
      ioctl_addr = 25'h00010;
      ioctl_dout = 8'hA5;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
      n_checks++;
      if (bram_wr !== 1'b1 || bram_addr !== 25'h00010 || bram_data !== 8'hA5)
         $display("FAIL bram_latency got %b/%h/%h expected 1/00010/a5", bram_wr, bram_addr, bram_data);
      else n_pass++;
      n_checks++;
      if (sdr_req !== 1'b0) $display("FAIL bram_no_sdr got sdr_req=%b expected 0", sdr_req);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bram_wr !== 1'b0) $display("FAIL bram_one_cycle got bram_wr=%b expected 0", bram_wr);
      else n_pass++;
      end_dl();
   endtask

   task automatic test_sdram_pair();
      int cnt;
      bit wait_bad;
      start_dl();
      ack_lat = 5;
      push_sdr(24'h0, 16'h1234, 2'b11);
      wr_byte(25'h80000, 8'h34);
      n_checks++;
      if (sdr_req !== 1'b0 || ioctl_wait !== 1'b0)
         $display("FAIL pair_even_held got req=%b wait=%b expected 0/0", sdr_req, ioctl_wait);
      else n_pass++;
      wr_byte(25'h80001, 8'h12);
      n_checks++;
      if (sdr_req !== 1'b1 || ioctl_wait !== 1'b1)
         $display("FAIL pair_req_rise got req=%b wait=%b expected 1/1", sdr_req, ioctl_wait);
      else n_pass++;
      cnt      = 0;
      wait_bad = 0;
      while (sdr_req && cnt < 50) begin
         if (ioctl_wait !== 1'b1) wait_bad = 1;
         cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (cnt != 5) $display("FAIL pair_req_len got %0d cycles expected 5", cnt);
      else n_pass++;
      n_checks++;
      if (wait_bad || ioctl_wait !== 1'b0)
         $display("FAIL pair_wait got wait_bad=%b wait_after=%b expected 0/0", wait_bad, ioctl_wait);
      else n_pass++;
      ack_lat = 2;
      end_dl();
   endtask

   task automatic test_trailing();
      start_dl();
      push_sdr(24'h2, 16'h0077, 2'b01);
      wr_byte(25'h80004, 8'h77);
      repeat (2) @(negedge clk);
      n_checks++;
      if (sdr_req !== 1'b0) $display("FAIL trailing_held got sdr_req=%b expected 0", sdr_req);
      else n_pass++;
      end_dl();
   endtask

   task automatic test_overrun();
      int n;
      start_dl();
      ack_lat = 4;
      push_sdr(24'h0, 16'h00AA, 2'b01);
      push_sdr(24'h1, 16'hBB00, 2'b10);
      wr_byte(25'h80000, 8'hAA);
      wr_byte(25'h80003, 8'hBB);
      n_checks++;
      if (ioctl_wait !== 1'b1) $display("FAIL overrun_wait got %b expected 1", ioctl_wait);
      else n_pass++;
      ioctl_addr = 25'h80002;
      ioctl_dout = 8'hEE;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
      n_checks++;
      if (overrun !== 1'b1) $display("FAIL overrun_set got %b expected 1", overrun);
      else n_pass++;
      n = 0;
      while (ioctl_wait && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (overrun !== 1'b1 || ioctl_wait !== 1'b0)
         $display("FAIL overrun_sticky got overrun=%b wait=%b expected 1/0", overrun, ioctl_wait);
      else n_pass++;
      ack_lat = 2;
      end_dl();
      n_checks++;
      if (overrun !== 1'b1) $display("FAIL overrun_hold got %b expected 1", overrun);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      start_dl();
      ack_en = 0;
      push_sdr(24'h20, 16'h0011, 2'b01);
      wr_byte(25'h80040, 8'h11);
      wr_byte(25'h80043, 8'h22);
      repeat (2) @(negedge clk);
      n_checks++;
      if (sdr_req !== 1'b1) $display("FAIL midreq_pending got sdr_req=%b expected 1", sdr_req);
      else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({sdr_req, ioctl_wait, bram_wr, rom_ready, overrun} !== 5'b0 ||
          sdr_be !== 2'b0 || sdr_addr !== '0 || sdr_data !== 16'h0)
         $display("FAIL midreq_async got req=%b wait=%b be=%b addr=%h data=%h expected all 0",
                  sdr_req, ioctl_wait, sdr_be, sdr_addr, sdr_data);
      else n_pass++;
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      ack_en = 1;
      @(negedge clk);
      start_dl();
      push_sdr(24'h10, 16'h7800, 2'b10);
      wr_byte(25'h80021, 8'h78);
      end_dl();
   endtask

   task automatic test_back_to_back();
      logic [7:0] d0, d1, db;
      start_dl();
      ack_lat = 2;
      for (int i = 0; i < 8; i++) begin
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         db = 8'($urandom);
         push_sdr(24'h80 + 24'(i), {d1, d0}, 2'b11);
         wr_byte(25'h80100 + 25'(2 * i), d0);
         wr_byte(25'h80101 + 25'(2 * i), d1);
         push_bram(25'h00200 + 25'(i), db);
         wr_byte(25'h00200 + 25'(i), db);
      end
      end_dl();
   endtask

`ifdef ROM_LOAD_CHECKSUM_EN
   task automatic test_checksum();
      start_dl();
      push_bram(25'h0, 8'hFF);
      wr_byte(25'h0, 8'hFF);
      push_sdr(24'h0, 16'h02FF, 2'b11);
      wr_byte(25'h80000, 8'hFF);
      wr_byte(25'h80001, 8'h02);
      end_dl();
      n_checks++;
      if (checksum !== 16'h0200) $display("FAIL checksum got %h expected 0200", checksum);
      else n_pass++;
   endtask
`endif

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      ack_lat        = 2;
      ack_en         = 1;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      sdr_ack        = 1'b0;
      fork
         monitor();
      join_none
      test_reset();
      test_bram();
      test_sdram_pair();
      test_trailing();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
`ifdef ROM_LOAD_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences the HPS ROM download stream into the core's two ROM stores: byte-wide BRAM EPROM images in the low address region and 16-bit SDRAM for everything above it. It sits between the `ioctl_*` download interface and the BRAM/SDRAM write ports. It packs byte pairs into SDRAM words, runs the SDRAM request/acknowledge handshake, and throttles the HPS with `ioctl_wait`. It reports load completion with `rom_ready`.

## Interface
- `BRAM_LIMIT`, default `'h80000`: first byte address routed to SDRAM; addresses below it go to BRAM.
- `SDR_AW`, default 24: SDRAM word address width.

- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ioctl_download` in 1: download in progress (level).
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: HPS must not strobe while high.
- `bram_wr` out 1: one-cycle BRAM write strobe.
- `bram_addr` out 25: registered byte address; external selector decodes it.
- `bram_data` out 8: registered byte.
- `sdr_req` out 1: SDRAM write request, held until ack.
- `sdr_ack` in 1: one-cycle acknowledge from SDRAM controller.
- `sdr_addr` out SDR_AW: word address = (byte addr − BRAM_LIMIT) >> 1.
- `sdr_data` out 16: {odd byte, even byte}.
- `sdr_be` out 2: byte enables; [0] = even/low, [1] = odd/high.
- `rom_ready` out 1: high after a download fully committed.
- `overrun` out 1: sticky; a strobe arrived while `ioctl_wait` was high.
- `checksum` out 16: present only with the macro (see Configuration).

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE → LOAD on `ioctl_download` rising edge (registered edge detect). On entry: clear `rom_ready`, `overrun`, pending register and checksum.
- LOAD, `ioctl_wr` with addr < BRAM_LIMIT: register addr/data and pulse `bram_wr`. Does not touch pending SDRAM state.
- LOAD, `ioctl_wr` with addr ≥ BRAM_LIMIT, even byte, no pending: store it in the pending low byte with its word address.
- Even byte while another even byte is pending: issue the old pending byte as a request with be=01; the new byte becomes pending.
- Odd byte whose word address matches the pending word: issue the word with be=11 and clear pending.
- Odd byte with no pending, or a different word address: issue it alone with be=10 (low byte 0x00). An unrelated pending byte is first issued with be=01 in the same request slot only if `sdr_req` is idle; otherwise it stays pending.
- Request handshake: `sdr_req`, `sdr_addr`, `sdr_data` and `sdr_be` are stable from assertion until the cycle `sdr_ack` is sampled high. `sdr_req` drops the next cycle.
- `ioctl_wait` = `sdr_req` OR (pending byte queued behind an outstanding request).
- Strobe while `ioctl_wait` is high: byte dropped and `overrun` set.
- LOAD → FLUSH on `ioctl_download` falling edge.
- FLUSH: wait for any outstanding ack, then issue any pending even byte (be=01) and wait for its ack, then go to DONE.
- DONE: `rom_ready`=1. Go to IDLE the same cycle. `rom_ready` holds until the next download rising edge.
- `ioctl_wr` outside LOAD is ignored (no overrun).

## Timing
- Reset values: state IDLE; `bram_wr`, `sdr_req`, `ioctl_wait`, `rom_ready`, `overrun` = 0; `sdr_be` = 0; `sdr_addr`, `sdr_data`, `bram_addr`, `bram_data` = 0; `checksum` = 0.
- BRAM latency: `bram_wr` is high exactly the cycle after `ioctl_wr`.
- SDRAM: `sdr_req` and `ioctl_wait` rise the cycle after the completing strobe.
- Fastest request cycle is 3 clocks: req, ack, idle.
- `sdr_ack` in the same cycle as the download falling edge: the ack is honoured and FLUSH sees no outstanding request.
- Reset mid-request: `sdr_req` drops immediately (asynchronous) and the pending byte is lost.

## Configuration
- `ROM_LOAD_CHECKSUM_EN` defined: a 16-bit wrapping sum of every accepted byte (both regions; dropped bytes excluded) is available on `checksum`, valid when `rom_ready`=1.
- Macro undefined: `checksum` port and adder are absent.

## Test plan
- BRAM byte: wr addr 0x00010, data 0xA5 → next cycle `bram_wr`=1, `bram_addr`=0x00010, `bram_data`=0xA5; `sdr_req` stays 0.
- SDRAM pair: wr 0x80000=0x34, then 0x80001=0x12 → `sdr_req`=1, `sdr_addr`=0, `sdr_data`=0x1234, `sdr_be`=11. `ioctl_wait` holds until ack 5 cycles later, then `sdr_req` drops.
- Trailing even byte: wr 0x80004=0x77, then drop `ioctl_download` → FLUSH issues `sdr_addr`=2, be=01, low byte 0x77; after ack, `rom_ready`=1.
- Overrun: strobe at 0x80002 while `ioctl_wait`=1 → byte not written and `overrun`=1 until the next download start.
- Reset mid-request: assert `reset` while `sdr_req`=1 → all outputs at reset values the same cycle; a new download proceeds normally.
- With `ROM_LOAD_CHECKSUM_EN`: bytes 0xFF, 0xFF, 0x02 → `checksum`=0x0200.
